// File: rtl/rf_wr_arbiter_pkg.sv
// Shared widths, register-zero index and grant encodings for the register-file write arbiter.
package rf_wr_arbiter_pkg;

  localparam int RF_DATA_W     = 32;
  localparam int RF_ADDR_W     = 5;
  localparam int RF_FIFO_DEPTH = 2;
  localparam int RF_STARVE_MAX = 4;
  localparam int REG_ZERO      = 0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MDU  = 2'd2,
    GNT_DBG  = 2'd3
  } gnt_e;

endpackage

// File: rtl/rf_wr_arbiter_fifo.sv
// Circular buffer of MDU results; each entry carries a live bit that a younger WB write
// to the same register can clear, so the stale result pops later without being written.
module rf_wr_arbiter_fifo import rf_wr_arbiter_pkg::*; #(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = RF_FIFO_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] kill_addr_i,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_live_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  live_q, live_d;
  logic [DEPTH-1:0]  occ;
  logic [PTR_W-1:0]  off;
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == CNT_W'(DEPTH));
  assign head_addr_o = addr_mem[rd_q];
  assign head_data_o = data_mem[rd_q];
  assign head_live_o = !empty_o && live_q[rd_q];

  // A slot is occupied when its distance from the read pointer is below the entry count
  always_comb begin
    occ = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off    = PTR_W'(i) - rd_q;
      occ[i] = ({1'b0, off} < cnt_q);
    end
  end

  always_comb begin
    live_d = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_i && occ[i] && (addr_mem[i] == kill_addr_i)) begin
        live_d[i] = 1'b0;
      end
    end
    // The entry pushed this cycle is older than nothing, so it is never killed
    if (push_i) begin
      live_d[wr_q] = 1'b1;
    end
    rd_d  = pop_i  ? rd_q + PTR_W'(1) : rd_q;
    wr_d  = push_i ? wr_q + PTR_W'(1) : wr_q;
    cnt_d = cnt_q;
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !push_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      live_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      live_q <= live_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      addr_mem[wr_q] <= push_addr_i;
      data_mem[wr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: WB stage first, then buffered MDU results, then debug.
// Tracks how long a live MDU result has been starved and asks the hazard unit for a bubble.
module rf_wr_arbiter import rf_wr_arbiter_pkg::*; #(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int FIFO_DEPTH = RF_FIFO_DEPTH,
  parameter int STARVE_MAX = RF_STARVE_MAX
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_waddr_i,
  input  logic [DATA_W-1:0] wb_wdata_i,
  input  logic              mdu_valid_i,
  input  logic [ADDR_W-1:0] mdu_waddr_i,
  input  logic [DATA_W-1:0] mdu_wdata_i,
  output logic              mdu_ready_o,
  input  logic              dbg_valid_i,
  input  logic [ADDR_W-1:0] dbg_waddr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_ready_o,
  output logic              stall_req_o,
  output logic              busy_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o
);

  localparam int                ST_W      = $clog2(STARVE_MAX + 1);
  localparam logic [ST_W-1:0]   ST_SAT    = ST_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  gnt_e              gnt;
  logic              wb_valid, push, pop;
  logic              fifo_empty, fifo_full, head_live;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [ST_W-1:0]   starve_q, starve_d;
  logic              stall_q, stall_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  assign wb_valid    = wb_we_i && (wb_waddr_i != ZERO_ADDR);
  assign push        = mdu_valid_i && !fifo_full && (mdu_waddr_i != ZERO_ADDR);
  assign pop         = !fifo_empty && (!head_live || (gnt == GNT_MDU));
  assign mdu_ready_o = !fifo_full;
  assign busy_o      = !fifo_empty;
  assign dbg_ready_o = (gnt == GNT_DBG);
  assign stall_req_o = stall_q;
  assign rf_we_o     = rf_we_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_wdata_o  = rf_wdata_q;

  rf_wr_arbiter_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_addr_i (mdu_waddr_i),
    .push_data_i (mdu_wdata_i),
    .pop_i       (pop),
    .kill_i      (wb_valid),
    .kill_addr_i (wb_waddr_i),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .head_live_o (head_live),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (wb_valid) begin
      gnt = GNT_WB;
    end else if (head_live) begin
      gnt = GNT_MDU;
    end else if (dbg_valid_i) begin
      gnt = GNT_DBG;
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    case (gnt)
      GNT_WB: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = wb_waddr_i;
        rf_wdata_d = wb_wdata_i;
      end
      GNT_MDU: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = head_addr;
        rf_wdata_d = head_data;
      end
      // Debug writes to r0 are acknowledged but never reach the register file
      GNT_DBG: begin
        if (dbg_waddr_i != ZERO_ADDR) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = dbg_waddr_i;
          rf_wdata_d = dbg_wdata_i;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (head_live && (gnt == GNT_WB) && (starve_q != ST_SAT)) begin
      starve_d = starve_q + ST_W'(1);
    end
    stall_d = stall_q;
    if (pop) begin
      stall_d = 1'b0;
    end else if (starve_d == ST_SAT) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q   <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // The hazard unit should hold WB off while stalled; if it does not, WB must still win
  always @(posedge clk_i) begin
    if (!rst_i && stall_q && wb_valid) begin
      assert (gnt == GNT_WB);
    end
  end

endmodule
